// File: rtl/slice_add_seq.sv
// Multi-cycle adder: WIDTH-bit add performed SLICE bits per clock, LSB slice first.
// Define SLICE_ADD_SUB_EN to add a 'sub' input that selects a - b.
module slice_add_seq #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SLICE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SLICE_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int unsigned NSLICE = WIDTH / SLICE;
  localparam int unsigned IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDXW-1:0] LAST = IDXW'(NSLICE - 1);

  if (SLICE == 0 || WIDTH == 0 || (WIDTH % SLICE) != 0) begin : g_bad_cfg
    $error("slice_add_seq: WIDTH must be a nonzero integer multiple of SLICE");
  end

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;

  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;
  logic [SLICE-1:0] sl_a, sl_b;
  logic [SLICE:0]   s;

`ifdef SLICE_ADD_SUB_EN
  // Subtract as a + ~b + 1; the forced carry-in replaces cin.
  assign b_eff   = sub ? ~b : b;
  assign cin_eff = sub ? 1'b1 : cin;
`else
  assign b_eff   = b;
  assign cin_eff = cin;
`endif

  always_comb begin
    sl_a = op_a_q[idx_q*SLICE +: SLICE];
    sl_b = op_b_q[idx_q*SLICE +: SLICE];
    s    = {1'b0, sl_a} + {1'b0, sl_b} + (SLICE+1)'(carry_q);
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          op_a_d  = a;
          op_b_d  = b_eff;
          carry_d = cin_eff;
          idx_d   = '0;
          sum_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        sum_d[idx_q*SLICE +: SLICE] = s[SLICE-1:0];
        carry_d = s[SLICE];
        if (idx_q == LAST) begin
          cout_d  = s[SLICE];
          state_d = StDone;
        end else begin
          idx_d = idx_q + IDXW'(1);
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      carry_q <= 1'b0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign out_valid = (state_q == StDone);
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_slice_add_seq.sv
// Self-checking bench for slice_add_seq: scoreboard of expected {cout, sum} per accepted op.
// Define SLICE_ADD_SUB_EN to also exercise subtraction.
module tb_slice_add_seq;
  localparam int unsigned WIDTH  = 16;
  localparam int unsigned SLICE  = 4;
  localparam int unsigned NSLICE = WIDTH / SLICE;
  localparam int          MAXWAIT = 50;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a, b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;

  int checks = 0;
  int errors = 0;
  logic [WIDTH:0] sb[$];

  always #5 clk = ~clk;

  slice_add_seq #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef SLICE_ADD_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  // Present one operand set for a single edge and record its expected result.
  task automatic send_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                         input logic cv, input logic sv);
    logic [WIDTH:0] e;
    logic [WIDTH-1:0] nb;
    nb = ~bv;
    if (sv) e = {1'b0, av} + {1'b0, nb} + (WIDTH+1)'(1);
    else    e = {1'b0, av} + {1'b0, bv} + (WIDTH+1)'(cv);
    a = av; b = bv; cin = cv; sub = sv; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    sb.push_back(e);
  endtask

  // Count edges until out_valid; returns MAXWAIT if it never rises.
  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < MAXWAIT) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (sum !== '0) begin errors++; $display("FAIL reset_sum got %h want 0000", sum); end
    checks++; if (cout !== 1'b0) begin errors++; $display("FAIL reset_cout got %b want 0", cout); end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_add_basic();
    logic [WIDTH-1:0] va[3] = '{16'h00FF, 16'hFFFF, 16'h1234};
    logic [WIDTH-1:0] vb[3] = '{16'h0001, 16'h0001, 16'h4321};
    logic             vc[3] = '{1'b0, 1'b0, 1'b1};
    logic [WIDTH:0] e;
    int lat;
    for (int i = 0; i < 3; i++) begin
      send_op(va[i], vb[i], vc[i], 1'b0);
      checks++; if (busy !== 1'b1 || in_ready !== 1'b0) begin
        errors++; $display("FAIL basic_run_flags[%0d] got busy=%b in_ready=%b want 1/0", i, busy, in_ready);
      end
      wait_done(lat);
      checks++; if (lat !== int'(NSLICE)) begin
        errors++; $display("FAIL basic_latency[%0d] got %0d want %0d", i, lat, NSLICE);
      end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_done_busy[%0d] got %b want 1", i, busy); end
      e = sb.pop_front();
      checks++; if ({cout, sum} !== e) begin
        errors++; $display("FAIL basic_result[%0d] got cout=%b sum=%h want cout=%b sum=%h", i, cout, sum, e[WIDTH], e[WIDTH-1:0]);
      end
      release_result();
    end
  endtask

  task automatic test_backpressure();
    logic [WIDTH:0] e;
    int lat;
    send_op(16'h1234, 16'h4321, 1'b1, 1'b0);
    wait_done(lat);
    e = sb.pop_front();
    checks++; if (lat !== int'(NSLICE)) begin errors++; $display("FAIL bp_latency got %0d want %0d", lat, NSLICE); end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b1 || {cout, sum} !== e) begin
        errors++; $display("FAIL bp_hold[%0d] got v=%b cout=%b sum=%h want v=1 cout=%b sum=%h", i, out_valid, cout, sum, e[WIDTH], e[WIDTH-1:0]);
      end
    end
    release_result();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL bp_idle got v=%b in_ready=%b busy=%b want 0/1/0", out_valid, in_ready, busy);
    end
    checks++; if ({cout, sum} !== e) begin
      errors++; $display("FAIL bp_keep got cout=%b sum=%h want cout=%b sum=%h", cout, sum, e[WIDTH], e[WIDTH-1:0]);
    end
  endtask

  // Called right after a release: accept must land on the very next edge.
  task automatic test_back_to_back();
    logic [WIDTH:0] e;
    int lat;
    send_op(16'hA5A5, 16'h5A5B, 1'b0, 1'b0);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept got busy=%b want 1", busy); end
    wait_done(lat);
    e = sb.pop_front();
    checks++; if (lat !== int'(NSLICE) || {cout, sum} !== e) begin
      errors++; $display("FAIL b2b_result got lat=%0d cout=%b sum=%h want lat=%0d cout=%b sum=%h", lat, cout, sum, NSLICE, e[WIDTH], e[WIDTH-1:0]);
    end
    release_result();
  endtask

  task automatic test_ignore_run();
    logic [WIDTH:0] e;
    int lat;
    int bad;
    send_op(16'h0A0B, 16'h0102, 1'b0, 1'b0);
    lat = 0; bad = 0;
    while (!out_valid && lat < MAXWAIT) begin
      a = WIDTH'($urandom); b = WIDTH'($urandom); cin = 1'($urandom); in_valid = 1'b1;
      @(posedge clk); #1;
      lat++;
      if (in_ready !== 1'b0) bad++;
    end
    repeat (2) begin
      @(posedge clk); #1;
      if (in_ready !== 1'b0 || out_valid !== 1'b1) bad++;
    end
    in_valid = 1'b0;
    e = sb.pop_front();
    checks++; if (bad !== 0) begin errors++; $display("FAIL ign_in_ready got %0d bad cycles want 0", bad); end
    checks++; if (lat !== int'(NSLICE) || {cout, sum} !== e) begin
      errors++; $display("FAIL ign_result got lat=%0d cout=%b sum=%h want lat=%0d cout=%b sum=%h", lat, cout, sum, NSLICE, e[WIDTH], e[WIDTH-1:0]);
    end
    release_result();
  endtask

  task automatic test_reset_mid();
    logic [WIDTH:0] e;
    int lat;
    send_op(16'h0FF5, 16'h00F1, 1'b0, 1'b0);
    repeat (2) begin @(posedge clk); #1; end
    #3 rst = 1'b1;
    #1;
    void'(sb.pop_back());
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL rstmid_flags got v=%b in_ready=%b busy=%b want 0/1/0", out_valid, in_ready, busy);
    end
    checks++; if (sum !== '0 || cout !== 1'b0) begin
      errors++; $display("FAIL rstmid_clear got cout=%b sum=%h want 0/0000", cout, sum);
    end
    @(posedge clk); #1 rst = 1'b0;
    send_op(16'h0003, 16'h0004, 1'b0, 1'b0);
    wait_done(lat);
    e = sb.pop_front();
    checks++; if (lat !== int'(NSLICE) || {cout, sum} !== e || sum !== 16'h0007) begin
      errors++; $display("FAIL rstmid_next got lat=%0d cout=%b sum=%h want lat=%0d cout=0 sum=0007", lat, cout, sum, NSLICE);
    end
    release_result();
  endtask

`ifdef SLICE_ADD_SUB_EN
  task automatic test_sub();
    logic [WIDTH-1:0] va[3] = '{16'h0005, 16'h0007, 16'h1234};
    logic [WIDTH-1:0] vb[3] = '{16'h0007, 16'h0005, 16'h0034};
    logic             vs[3] = '{1'b1, 1'b1, 1'b0};
    logic [WIDTH:0] e;
    int lat;
    for (int i = 0; i < 3; i++) begin
      send_op(va[i], vb[i], 1'b0, vs[i]);
      wait_done(lat);
      e = sb.pop_front();
      checks++; if (lat !== int'(NSLICE) || {cout, sum} !== e) begin
        errors++; $display("FAIL sub_result[%0d] got lat=%0d cout=%b sum=%h want lat=%0d cout=%b sum=%h", i, lat, cout, sum, NSLICE, e[WIDTH], e[WIDTH-1:0]);
      end
      release_result();
    end
  endtask
`endif

  initial begin
    test_reset();
    test_add_basic();
    test_backpressure();
    test_back_to_back();
    test_ignore_run();
    test_reset_mid();
`ifdef SLICE_ADD_SUB_EN
    test_sub();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/slice_add_seq.md
Name: slice_add_seq

Overview:
- Multi-cycle sequencer that adds two WIDTH-bit operands using one SLICE-bit full-adder ripple slice, one slice per clock, LSB slice first.
- Holds the inter-slice carry in a register and assembles the result in a shift/index register.
- Valid/ready handshake on both sides.
- Sits between operand producers and result consumers wherever a wide adder is too costly or too slow in one cycle.

Parameters:
- WIDTH, 16, operand/result width; must be an integer multiple of SLICE (elaboration error otherwise)
- SLICE, 4, bits added per clock by the internal ripple slice; NSLICE = WIDTH/SLICE ≥ 1

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous reset, active-high
- in_valid  input  1  operands present
- in_ready  output  1  block can accept operands
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry into slice 0
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- sum  output  WIDTH  result
- cout  output  1  carry out of the final slice
- busy  output  1  high in RUN or DONE

Behaviour:
- States: IDLE, RUN, DONE. Registered state; all outputs come from registers or decode state only.
- Reset (async, any state, including mid-RUN):
  - state=IDLE, slice index=0, carry reg=0, sum=0, cout=0.
  - out_valid=0, busy=0, in_ready=1 from the reset assertion onward.
  - Any in-progress operation is discarded.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready at an edge: latch a, b into operand regs; carry reg←cin; idx←0; sum←0; go to RUN.
- RUN (in_ready=0, busy=1), each edge:
  - s = opA[idx*SLICE +: SLICE] + opB[idx*SLICE +: SLICE] + carry reg (SLICE+1 bits).
  - sum[idx*SLICE +: SLICE] ← s[SLICE-1:0]; carry reg ← s[SLICE].
  - If idx==NSLICE-1: cout ← s[SLICE]; go to DONE. Otherwise idx←idx+1.
- DONE:
  - out_valid=1; sum/cout stable.
  - On out_ready high at an edge: go to IDLE, out_valid drops. sum and cout keep their values until the next accept.
- Latency: operands accepted at edge k → out_valid first high after edge k+NSLICE.
  - Minimum accept-to-accept spacing is NSLICE+2 edges: the DONE handshake edge, then one IDLE cycle. No accept in DONE.
- a, b, cin, in_valid changes during RUN/DONE are ignored; the latched operands are used.
- out_ready is ignored outside DONE.
- Arithmetic is unsigned modulo 2^WIDTH; cout is the true carry out of bit WIDTH-1.
- NSLICE=1 degenerates to one RUN cycle.

Optional Feature:
- Macro: SLICE_ADD_SUB_EN
- Defined:
  - Adds input port sub (1 bit), sampled with the operands at accept.
  - sub=1 latches ~b as operand B and sets carry reg←1 (cin ignored), computing a−b mod 2^WIDTH.
  - cout=1 means no borrow (a≥b unsigned); cout=0 means borrow.
  - sub=0 gives exactly the add behaviour.
- Not defined: no sub port; add only.

Test Plan:
- WIDTH=16, SLICE=4: a=0x00FF, b=0x0001, cin=0 accepted at edge k → out_valid after edge k+4, sum=0x0100, cout=0; busy high during RUN and DONE.
- a=0xFFFF, b=0x0001, cin=0 → sum=0x0000, cout=1 (carry propagates through all 4 slices). Also a=0x1234, b=0x4321, cin=1 → sum=0x5556, cout=0.
- Backpressure: out_ready held low 3 cycles in DONE → out_valid, sum, cout stable. out_ready high → IDLE next edge; in_ready=1; next accept possible one edge later.
- During RUN, drive in_valid=1 with new a/b each cycle → ignored; result matches the first latched pair; in_ready=0 throughout RUN/DONE.
- Assert rst asynchronously mid-edge while idx=2 → immediately IDLE, out_valid=0, sum=0, cout=0, in_ready=1. Next operation a=0x0003, b=0x0004 → sum=0x0007, with no stale carry.
- SLICE_ADD_SUB_EN defined: a=0x0005, b=0x0007, sub=1 → sum=0xFFFE, cout=0. a=0x0007, b=0x0005, sub=1 → sum=0x0002, cout=1.
